alu_op_issuer: RTL
==================

Name: alu_op_issuer

Overview:
- Request-side master for the ALU operand/opcode interface: the block that drives A, B, a_en, b_en, a_op, b_op and ALU_en and reads back C.
- Accepts logical ALU commands on a valid/ready request port and buffers them in an internal FIFO.
- Encodes each command into the ALU's enable/opcode scheme, issues it for exactly one cycle, captures the registered result and returns it with its tag on a valid/ready response port.
- Sits between any command source (CPU shim, test sequencer) and the ALU.

Parameters:
- DATA_WIDTH, 5, operand width; result width is DATA_WIDTH+1.
- DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2.
- TAG_WIDTH, 4, width of the request/response tag.

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_opcode  in  4  logical op: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR, 5 XNOR, 6 NAND, 7 DEC_A (A-1), 8 INC2_B (B+2); 9-15 illegal
- req_a, req_b  in  DATA_WIDTH  signed operands
- req_tag  in  TAG_WIDTH  returned unchanged with the response
- A, B  out  DATA_WIDTH  ALU operands (registered)
- a_en, b_en  out  1  ALU group enables (registered)
- a_op  out  3  ALU a-group opcode (registered)
- b_op  out  2  ALU b-group opcode (registered)
- ALU_en  out  1  ALU enable (registered)
- C  in  DATA_WIDTH+1  ALU registered result
- rsp_valid  out  1  response present
- rsp_ready  in  1  response accepted
- rsp_data  out  DATA_WIDTH+1  captured C; 0 on error
- rsp_tag  out  TAG_WIDTH  tag of the completed request
- rsp_err  out  1  illegal opcode, not issued
- busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
Reset (async, rst_n=0):
- All outputs 0, except req_ready=1 once the FIFO is empty.
- FIFO emptied; FSM returns to IDLE.
- Any in-flight command is discarded and no response is produced for it.

Request FIFO:
- Push when req_valid && req_ready; req_ready = !full.
- No bypass: a pushed entry is visible to the FSM the cycle after the push.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- A push and a pop in the same cycle leave occupancy unchanged.

Encoding (registered into the drive outputs on pop):
- ADD: a_en=1, b_en=0, a_op=0
- SUB: a_en=1, b_en=0, a_op=1
- XOR: a_en=1, b_en=0, a_op=2
- AND: a_en=1, b_en=0, a_op=3
- OR: a_en=1, b_en=0, a_op=5
- XNOR: a_en=1, b_en=0, a_op=6
- NAND: a_en=0, b_en=1, b_op=0
- DEC_A: a_en=1, b_en=1, b_op=2
- INC2_B: a_en=1, b_en=1, b_op=3
- Unused opcode field is driven 0.
- Never drive a_op=7, the a_en=0/b_en=1/b_op=3 combination, or a_en=b_en=0 with ALU_en=1.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop it.
  - Legal opcode: load A, B, enables and opcodes; go to ISSUE.
  - Illegal opcode: load rsp_tag, rsp_err=1, rsp_data=0; go to RESP. ALU_en stays 0.
- ISSUE: ALU_en=1 for exactly this one cycle; go to WAIT.
- WAIT: ALU_en=0; C is valid this cycle. Capture rsp_data<=C, rsp_tag, rsp_err=0; go to RESP.
- RESP: rsp_valid=1; hold rsp_data, rsp_tag and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE.
- No IDLE bypass: back-to-back commands are spaced 4 cycles apart.

Drive outputs outside ISSUE:
- A, B, a_en, b_en, a_op and b_op hold their last values.
- ALU_en=0, so the ALU's C must remain stable.

Latency:
- Legal command: pop cycle to rsp_valid is 3 cycles.
- Illegal command: pop cycle to rsp_valid is 1 cycle.
- With rsp_ready held high, one command completes every 4 cycles.

Arithmetic:
- The block performs no arithmetic; rsp_data is exactly the C sampled in WAIT.

Test Plan:
- ADD A=7, B=5, tag=3, with a behavioural ALU stub -> ALU_en high exactly 1 cycle with a_en=1, b_en=0, a_op=0; rsp_valid 3 cycles after pop; rsp_data=12, tag=3, err=0.
- SUB A=-3, B=4 -> rsp_data=-7 (6'h39). INC2_B B=15 -> a_en=b_en=1, b_op=3; rsp_data=17.
- NAND A=5'b10101, B=5'b01111 -> a_en=0, b_en=1, b_op=0; rsp_data=6'b011010 (26).
- Opcode 12, tag=9 -> ALU_en never asserted; rsp_valid 1 cycle after pop; err=1, data=0, tag=9.
- rsp_ready=0, push 6 back-to-back commands -> 1 in flight plus 4 queued accepted, then req_ready=0. Release rsp_ready -> responses arrive in order with correct tags; req_ready returns 1 cycle after the next pop.
- rst_n low during ISSUE -> all outputs 0 immediately, no response; after release, busy=0 and req_ready=1.

Source files
------------

// File: rtl/alu_op_issuer.sv
// alu_op_issuer
// Request-side master for the ALU operand/opcode interface. Logical ALU
// commands arrive on a valid/ready request port and are buffered in a small
// FIFO. Each command is encoded into the ALU enable/opcode scheme and issued
// for exactly one cycle. The registered ALU result C is then captured and
// returned with the command tag on a valid/ready response port.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (req_ready = FIFO not full)
//   req_opcode, req_a, req_b      logical opcode (0..8 legal) and signed operands
//   req_tag                       returned unchanged with the response
//   A, B, a_en, b_en, a_op, b_op  registered ALU operand/opcode drive
//   ALU_en                        registered ALU enable, high one cycle per command
//   C                             ALU registered result
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_tag, rsp_err    captured C (0 on error), tag, illegal-opcode flag
//   busy                          FSM not idle or FIFO not empty
module alu_op_issuer #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic                  a_en,
  output logic                  b_en,
  output logic [2:0]            a_op,
  output logic [1:0]            b_op,
  output logic                  ALU_en,
  input  logic [DATA_WIDTH:0]   C,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 4 + 2 * DATA_WIDTH + TAG_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Encoded drive word: {legal, a_en, b_en, a_op[2:0], b_op[1:0]}.
  // The unused opcode group is always 0; illegal opcodes yield all zeros.
  function automatic logic [7:0] encode_op(input logic [3:0] op);
    logic [7:0] enc;
    case (op)
      4'd0:    enc = {1'b1, 1'b1, 1'b0, 3'd0, 2'd0}; // ADD
      4'd1:    enc = {1'b1, 1'b1, 1'b0, 3'd1, 2'd0}; // SUB
      4'd2:    enc = {1'b1, 1'b1, 1'b0, 3'd2, 2'd0}; // XOR
      4'd3:    enc = {1'b1, 1'b1, 1'b0, 3'd3, 2'd0}; // AND
      4'd4:    enc = {1'b1, 1'b1, 1'b0, 3'd5, 2'd0}; // OR
      4'd5:    enc = {1'b1, 1'b1, 1'b0, 3'd6, 2'd0}; // XNOR
      4'd6:    enc = {1'b1, 1'b0, 1'b1, 3'd0, 2'd0}; // NAND
      4'd7:    enc = {1'b1, 1'b1, 1'b1, 3'd0, 2'd2}; // DEC_A
      4'd8:    enc = {1'b1, 1'b1, 1'b1, 3'd0, 2'd3}; // INC2_B
      default: enc = 8'd0;
    endcase
    return enc;
  endfunction

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_a_en;
  logic                  r_b_en;
  logic [2:0]            r_a_op;
  logic [1:0]            r_b_op;
  logic                  r_alu_en;
  logic [TAG_WIDTH-1:0]  r_cur_tag;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH:0]   r_rsp_data;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_rsp_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_head;
  logic [3:0]            w_head_op;
  logic [DATA_WIDTH-1:0] w_head_a;
  logic [DATA_WIDTH-1:0] w_head_b;
  logic [TAG_WIDTH-1:0]  w_head_tag;
  logic [7:0]            w_enc;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_push  = req_valid && !w_full;
  // The FSM only looks at the FIFO while idle, so a pop is exactly "idle and non-empty".
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_op  = w_head[ENTRY_W-1 -: 4];
  assign w_head_a   = w_head[TAG_WIDTH+2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign w_head_b   = w_head[TAG_WIDTH+DATA_WIDTH-1 -: DATA_WIDTH];
  assign w_head_tag = w_head[TAG_WIDTH-1:0];
  assign w_enc      = encode_op(w_head_op);

  // FIFO storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_opcode, req_a, req_b, req_tag};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/response FSM with all drive and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= {DATA_WIDTH{1'b0}};
      r_b         <= {DATA_WIDTH{1'b0}};
      r_a_en      <= 1'b0;
      r_b_en      <= 1'b0;
      r_a_op      <= 3'd0;
      r_b_op      <= 2'd0;
      r_alu_en    <= 1'b0;
      r_cur_tag   <= {TAG_WIDTH{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {(DATA_WIDTH+1){1'b0}};
      r_rsp_tag   <= {TAG_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_enc[7]) begin
              r_a       <= w_head_a;
              r_b       <= w_head_b;
              r_a_en    <= w_enc[6];
              r_b_en    <= w_enc[5];
              r_a_op    <= w_enc[4:2];
              r_b_op    <= w_enc[1:0];
              r_cur_tag <= w_head_tag;
              r_alu_en  <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              // Illegal opcode: never touches the ALU, reports straight away.
              r_rsp_tag   <= w_head_tag;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= {(DATA_WIDTH+1){1'b0}};
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_alu_en <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // The ALU registered the operands at the end of ISSUE, so C is valid now.
          r_rsp_data  <= C;
          r_rsp_tag   <= r_cur_tag;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_alu_en    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign A         = r_a;
  assign B         = r_b;
  assign a_en      = r_a_en;
  assign b_en      = r_b_en;
  assign a_op      = r_a_op;
  assign b_op      = r_b_op;
  assign ALU_en    = r_alu_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_err   = r_rsp_err;

endmodule
